// File: rtl/kf8237_channel_address_counter.sv
`default_nettype none
// ============================================================================
// Module   : kf8237_channel_address_counter
// Brief    : KF8237 per-channel base/current address and word-count registers,
//            shared CPU byte pointer, per-transfer stepping and terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module kf8237_channel_address_counter #(
    parameter int CHANNELS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          internal_data_bus,
    input  logic [CHANNELS-1:0] write_base_and_current_address,
    input  logic [CHANNELS-1:0] write_base_and_current_word_count,
    input  logic                clear_byte_pointer,
    input  logic                master_clear,
    input  logic [CHANNELS-1:0] read_current_address,
    input  logic [CHANNELS-1:0] read_current_word_count,
    input  logic [1:0]          dma_channel,
    input  logic                next_word,
    input  logic [CHANNELS-1:0] address_decrement,
    input  logic [CHANNELS-1:0] autoinitialize,
    output logic [7:0]          read_data,
    output logic [15:0]         transfer_address,
    output logic [CHANNELS-1:0] terminal_count
);

    logic [15:0]         r_base_addr  [CHANNELS];
    logic [15:0]         r_cur_addr   [CHANNELS];
    logic [15:0]         r_base_count [CHANNELS];
    logic [15:0]         r_cur_count  [CHANNELS];
    logic                r_byte_pointer;
    logic                r_read_prev;
    logic [CHANNELS-1:0] r_terminal_count;

    logic [15:0]         w_base_addr_nxt  [CHANNELS];
    logic [15:0]         w_cur_addr_nxt   [CHANNELS];
    logic [15:0]         w_base_count_nxt [CHANNELS];
    logic [15:0]         w_cur_count_nxt  [CHANNELS];
    logic [CHANNELS-1:0] w_tc;
    logic                w_read_any;
    logic                w_write_any;
    logic                w_read_done;
    logic                w_byte_pointer_nxt;
    logic [7:0]          w_read_data;

    assign w_read_any  = |{read_current_address, read_current_word_count};
    assign w_write_any = |{write_base_and_current_address, write_base_and_current_word_count};
    assign w_read_done = r_read_prev & ~w_read_any;

    // Clear wins over a toggle; a coincident write already used the old pointer.
    always_comb begin
        w_byte_pointer_nxt = r_byte_pointer;
        if (clear_byte_pointer || master_clear) begin
            w_byte_pointer_nxt = 1'b0;
        end else if (w_write_any || w_read_done) begin
            w_byte_pointer_nxt = ~r_byte_pointer;
        end
    end

    // Transfer stepping first, then the CPU byte write overlays its byte only.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_tc[c]             = 1'b0;
            w_base_addr_nxt[c]  = r_base_addr[c];
            w_cur_addr_nxt[c]   = r_cur_addr[c];
            w_base_count_nxt[c] = r_base_count[c];
            w_cur_count_nxt[c]  = r_cur_count[c];

            if (next_word && (int'(dma_channel) == c)) begin
                w_cur_addr_nxt[c]  = address_decrement[c] ? (r_cur_addr[c] - 16'd1)
                                                          : (r_cur_addr[c] + 16'd1);
                w_cur_count_nxt[c] = r_cur_count[c] - 16'd1;
                if (r_cur_count[c] == 16'h0000) begin
                    w_tc[c] = 1'b1;
                    if (autoinitialize[c]) begin
                        w_cur_addr_nxt[c]  = r_base_addr[c];
                        w_cur_count_nxt[c] = r_base_count[c];
                    end
                end
            end

            if (write_base_and_current_address[c]) begin
                if (r_byte_pointer) begin
                    w_base_addr_nxt[c][15:8] = internal_data_bus;
                    w_cur_addr_nxt[c][15:8]  = internal_data_bus;
                end else begin
                    w_base_addr_nxt[c][7:0]  = internal_data_bus;
                    w_cur_addr_nxt[c][7:0]   = internal_data_bus;
                end
            end

            if (write_base_and_current_word_count[c]) begin
                if (r_byte_pointer) begin
                    w_base_count_nxt[c][15:8] = internal_data_bus;
                    w_cur_count_nxt[c][15:8]  = internal_data_bus;
                end else begin
                    w_base_count_nxt[c][7:0]  = internal_data_bus;
                    w_cur_count_nxt[c][7:0]   = internal_data_bus;
                end
            end
        end
    end

    always_comb begin
        w_read_data = 8'h00;
        for (int c = 0; c < CHANNELS; c++) begin
            if (read_current_address[c]) begin
                w_read_data = w_read_data |
                    (r_byte_pointer ? r_cur_addr[c][15:8] : r_cur_addr[c][7:0]);
            end
            if (read_current_word_count[c]) begin
                w_read_data = w_read_data |
                    (r_byte_pointer ? r_cur_count[c][15:8] : r_cur_count[c][7:0]);
            end
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_base_addr[c]  <= 16'h0000;
                r_cur_addr[c]   <= 16'h0000;
                r_base_count[c] <= 16'h0000;
                r_cur_count[c]  <= 16'h0000;
            end
            r_byte_pointer   <= 1'b0;
            r_read_prev      <= 1'b0;
            r_terminal_count <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_base_addr[c]  <= w_base_addr_nxt[c];
                r_cur_addr[c]   <= w_cur_addr_nxt[c];
                r_base_count[c] <= w_base_count_nxt[c];
                r_cur_count[c]  <= w_cur_count_nxt[c];
            end
            r_byte_pointer   <= w_byte_pointer_nxt;
            r_read_prev      <= w_read_any;
            r_terminal_count <= w_tc;
        end
    end

    assign read_data        = w_read_data;
    assign transfer_address = r_cur_addr[dma_channel];
    assign terminal_count   = r_terminal_count;

endmodule
`default_nettype wire
